nla_batch_controller: RTL and testbench

//  Sequencer for the NLA polynomial/MAC datapath; generalised successor of the single-sample controller.

---
 rtl/nla_ctrl_pkg.sv | 23 ++
 rtl/nla_wait_timer.sv | 46 ++++
 rtl/nla_batch_controller.sv | 208 ++++++++++++++++++++
 tb/tb_nla_batch_controller.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nla_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nla_ctrl_pkg
// Shared definitions for the NLA batch controller:
//   STATE_W  - width of the controller state register
//   PERF_W   - width of the batch cycle counter
//   state_t  - controller states (LOAD, PRIME, CHECK, FETCH, WAIT, EMIT)
// No ports (package).
// -----------------------------------------------------------------------------
package nla_ctrl_pkg;

  localparam int STATE_W = 3;
  localparam int PERF_W  = 32;

  typedef enum logic [STATE_W-1:0] {
    LOAD  = 3'd0,
    PRIME = 3'd1,
    CHECK = 3'd2,
    FETCH = 3'd3,
    WAIT  = 3'd4,
    EMIT  = 3'd5
  } state_t;

endpackage

// File: rtl/nla_wait_timer.sv
// -----------------------------------------------------------------------------
// nla_wait_timer
// Load/count/expire counter that paces the MAC wait after each coefficient fetch.
// Ports:
//   clk     in   clock
//   rst_n   in   synchronous active-low reset (counter to 0)
//   load    in   restart the count at 0
//   count   in   advance the count by one
//   expire  out  high while the count equals MAC_LATENCY-1 (last wait cycle)
// -----------------------------------------------------------------------------
module nla_wait_timer #(
  parameter int MAC_LATENCY = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int CW = $clog2(MAC_LATENCY + 1);
  localparam logic [CW-1:0] LAST = CW'(MAC_LATENCY - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (count && !expire) begin
      // Holding at LAST keeps the counter from ever wrapping.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nla_batch_controller.sv
// -----------------------------------------------------------------------------
// nla_batch_controller
// Sequencer for the NLA polynomial/MAC datapath. Fills the signal/coeff buffers,
// then evaluates batch_len samples against one coefficient load: per coefficient
// one rd_en_coeff followed by MAC_LATENCY wait cycles. Results leave through a
// valid/ready handshake.
// Optional feature macro: NLA_CTRL_PERF_EN (batch cycle counter on perf_cycles;
// when undefined perf_cycles is tied to 0).
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   num_coeff, batch_len         coefficients per sample / samples per batch
//   sig_ready, coeff_ready       buffer-full flags from the write logic
//   abort                        return to LOAD next cycle
//   result_ready                 downstream accepts the result
//   rst_reg_n                    datapath register reset (low while rst_n low)
//   wr_en_signal, wr_en_coeff    buffer write enables
//   rd_en_signal, rd_en_coeff    buffer read strobes
//   redo_coeff, redo_data        coeff pointer rewind / accumulator clear hold
//   ld_result, result_valid      result register load / result available
//   busy, done                   state != LOAD / last result of batch accepted
//   perf_cycles                  batch cycle count
// -----------------------------------------------------------------------------
module nla_batch_controller
  import nla_ctrl_pkg::*;
#(
  parameter int ADDR_LINES  = 4,
  parameter int MAC_LATENCY = 10,
  parameter int BATCH_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_LINES-1:0] num_coeff,
  input  logic [BATCH_W-1:0]    batch_len,
  input  logic                  sig_ready,
  input  logic                  coeff_ready,
  input  logic                  abort,
  input  logic                  result_ready,
  output logic                  rst_reg_n,
  output logic                  wr_en_signal,
  output logic                  wr_en_coeff,
  output logic                  rd_en_signal,
  output logic                  rd_en_coeff,
  output logic                  redo_coeff,
  output logic                  redo_data,
  output logic                  ld_result,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           perf_cycles
);

  state_t                state_q, state_d;
  logic [ADDR_LINES-1:0] coeff_cnt_q, coeff_cnt_d;
  logic [ADDR_LINES-1:0] num_coeff_q, num_coeff_d;
  logic [BATCH_W-1:0]    samp_cnt_q, samp_cnt_d;
  logic                  timer_load, timer_count, timer_expire;

  assign rst_reg_n = rst_n;
  assign busy      = (state_q != LOAD);

  nla_wait_timer #(
    .MAC_LATENCY(MAC_LATENCY)
  ) u_wait_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .count (timer_count),
    .expire(timer_expire)
  );

  always_comb begin
    state_d      = state_q;
    coeff_cnt_d  = coeff_cnt_q;
    num_coeff_d  = num_coeff_q;
    samp_cnt_d   = samp_cnt_q;
    wr_en_signal = 1'b0;
    wr_en_coeff  = 1'b0;
    rd_en_signal = 1'b0;
    rd_en_coeff  = 1'b0;
    redo_coeff   = 1'b0;
    redo_data    = 1'b1;
    ld_result    = 1'b0;
    result_valid = 1'b0;
    done         = 1'b0;
    timer_load   = 1'b0;
    timer_count  = 1'b0;

    case (state_q)
      LOAD: begin
        if (!sig_ready) begin
          wr_en_signal = 1'b1;
        end else if (!coeff_ready) begin
          wr_en_coeff = 1'b1;
        end else begin
          rd_en_signal = 1'b1;
          redo_coeff   = 1'b1;
          // Batch geometry is frozen here; later input changes are ignored.
          num_coeff_d  = num_coeff;
          coeff_cnt_d  = num_coeff;
          samp_cnt_d   = (batch_len == '0) ? BATCH_W'(1) : batch_len;
          state_d      = PRIME;
        end
      end
      PRIME: begin
        redo_data = 1'b0;
        state_d   = CHECK;
      end
      CHECK: begin
        state_d = (coeff_cnt_q == '0) ? EMIT : FETCH;
      end
      FETCH: begin
        rd_en_coeff = 1'b1;
        timer_load  = 1'b1;
        if (coeff_cnt_q != '0) begin
          coeff_cnt_d = coeff_cnt_q - 1'b1;
        end
        state_d = WAIT;
      end
      WAIT: begin
        timer_count = 1'b1;
        if (timer_expire) begin
          state_d = CHECK;
        end
      end
      EMIT: begin
        ld_result    = 1'b1;
        result_valid = 1'b1;
        if (result_ready) begin
          if (samp_cnt_q == BATCH_W'(1)) begin
            done    = 1'b1;
            state_d = LOAD;
          end else begin
            samp_cnt_d   = samp_cnt_q - 1'b1;
            rd_en_signal = 1'b1;
            redo_coeff   = 1'b1;
            coeff_cnt_d  = num_coeff_q;
            state_d      = PRIME;
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase

    // Abort overrides everything, including a result handshake in EMIT.
    if (abort) begin
      state_d = LOAD;
    end
    if (abort || !rst_n) begin
      wr_en_signal = 1'b0;
      wr_en_coeff  = 1'b0;
      rd_en_signal = 1'b0;
      rd_en_coeff  = 1'b0;
      redo_coeff   = 1'b0;
      redo_data    = 1'b1;
      ld_result    = 1'b0;
      result_valid = 1'b0;
      done         = 1'b0;
      timer_load   = 1'b0;
      timer_count  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      coeff_cnt_q <= '0;
      num_coeff_q <= '0;
      samp_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      coeff_cnt_q <= coeff_cnt_d;
      num_coeff_q <= num_coeff_d;
      samp_cnt_q  <= samp_cnt_d;
    end
  end

`ifdef NLA_CTRL_PERF_EN
  logic              load_exit;
  logic [PERF_W-1:0] perf_q, perf_d;

  assign load_exit = (state_q == LOAD) && (state_d == PRIME);

  always_comb begin
    perf_d = perf_q;
    if (load_exit) begin
      // The LOAD-exit cycle is the first cycle of the batch.
      perf_d = PERF_W'(1);
    end else if (busy && (perf_q != '1)) begin
      perf_d = perf_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_nla_batch_controller.sv
// -----------------------------------------------------------------------------
// tb_nla_batch_controller
// Scoreboard bench: expected rd_en_coeff cycles and result handshakes are queued
// when a batch is launched and popped by a negedge monitor as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_nla_batch_controller;

  localparam int LAT = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  num_coeff;
  logic [3:0]  batch_len;
  logic        sig_ready, coeff_ready, abort, result_ready;
  logic        rst_reg_n, wr_en_signal, wr_en_coeff, rd_en_signal, rd_en_coeff;
  logic        redo_coeff, redo_data, ld_result, result_valid, busy, done;
  logic [31:0] perf_cycles;

  always #5 clk = ~clk;

  nla_batch_controller #(
    .ADDR_LINES (4),
    .MAC_LATENCY(LAT),
    .BATCH_W    (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .num_coeff   (num_coeff),
    .batch_len   (batch_len),
    .sig_ready   (sig_ready),
    .coeff_ready (coeff_ready),
    .abort       (abort),
    .result_ready(result_ready),
    .rst_reg_n   (rst_reg_n),
    .wr_en_signal(wr_en_signal),
    .wr_en_coeff (wr_en_coeff),
    .rd_en_signal(rd_en_signal),
    .rd_en_coeff (rd_en_coeff),
    .redo_coeff  (redo_coeff),
    .redo_data   (redo_data),
    .ld_result   (ld_result),
    .result_valid(result_valid),
    .busy        (busy),
    .done        (done),
    .perf_cycles (perf_cycles)
  );

  typedef struct {
    int cyc;
    bit dn;
  } emit_t;

  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    n_done = 0;
  int    n_ld = 0;
  int    n_rds = 0;
  int    exp_rc[$];
  emit_t exp_em[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected events for a batch launched at t0 with result_ready held high.
  task automatic push_batch(input int t0, input int nc, input int bl);
    int n, p, base;
    emit_t e;
    n = (bl == 0) ? 1 : bl;
    p = 3 + nc * (LAT + 2);
    for (int s = 0; s < n; s++) begin
      base = t0 + s * p;
      for (int j = 0; j < nc; j++) exp_rc.push_back(base + 3 + j * (LAT + 2));
      e.cyc = base + p;
      e.dn  = (s == n - 1);
      exp_em.push_back(e);
    end
  endtask

  task automatic goto_cyc(input int c);
    int k;
    k = 0;
    while (cyc < c && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic start_batch(input int nc, input int bl, output int t0);
    int k;
    num_coeff   = 4'(nc);
    batch_len   = 4'(bl);
    sig_ready   = 1'b1;
    coeff_ready = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rd_en_signal && k < 30);
    check_eq("start_rd_en_signal", rd_en_signal, 1);
    check_eq("start_redo_coeff", redo_coeff, 1);
    t0 = cyc;
    @(posedge clk); #1;
    sig_ready   = 1'b0;
    coeff_ready = 1'b0;
    $display("[TB] batch start nc=%0d bl=%0d t0=%0d", nc, bl, t0);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 1000);
    check_eq("idle_reached", busy, 0);
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard as strobes and handshakes appear.
  always @(negedge clk) begin : mon
    emit_t e;
    int    r;
    if (rd_en_coeff) begin
      if (exp_rc.size() == 0) begin
        check_eq("rd_en_coeff_unexpected", rd_en_coeff, 0);
      end else begin
        r = exp_rc.pop_front();
        check_eq("rd_en_coeff_cycle", cyc, r);
      end
    end
    if (result_valid && result_ready && !abort) begin
      if (exp_em.size() == 0) begin
        check_eq("emit_unexpected", result_valid, 0);
      end else begin
        e = exp_em.pop_front();
        check_eq("emit_cycle", cyc, e.cyc);
        check_eq("emit_done", done, e.dn);
        $display("[TB] result accepted cycle=%0d done=%0d", cyc, done);
      end
    end
    n_done = n_done + int'(done);
    n_ld   = n_ld + int'(ld_result);
    n_rds  = n_rds + int'(rd_en_signal);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, k, d0, l0, r0;
    rst_n = 1'b0; num_coeff = '0; batch_len = '0;
    sig_ready = 1'b0; coeff_ready = 1'b0; abort = 1'b0; result_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rst_reg_n", rst_reg_n, 0);
    check_eq("rst_redo_data", redo_data, 1);
    check_eq("rst_wr_en_signal", wr_en_signal, 0);
    check_eq("rst_perf", perf_cycles, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: buffer fill sequencing
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t1_wr_en_signal", wr_en_signal, 1);
      check_eq("t1_wr_en_coeff_off", wr_en_coeff, 0);
      check_eq("t1_rst_reg_n", rst_reg_n, 1);
      @(posedge clk); #1;
    end
    sig_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("t1_wr_en_coeff", wr_en_coeff, 1);
      check_eq("t1_wr_en_signal_off", wr_en_signal, 0);
      @(posedge clk); #1;
    end

    // 2: single sample, 3 coefficients
    d0 = n_done;
    start_batch(3, 1, t0);
    push_batch(t0, 3, 1);
    @(negedge clk);
    check_eq("t2_prime_redo_data", redo_data, 0);
    @(negedge clk);
    check_eq("t2_check_redo_data", redo_data, 1);
    goto_cyc(t0 + 40);
    @(negedge clk);
    check_eq("t2_back_to_load", busy, 0);
    check_eq("t2_done_count", n_done - d0, 1);
`ifdef NLA_CTRL_PERF_EN
    check_eq("t2_perf_cycles", perf_cycles, 40);
`else
    check_eq("t2_perf_cycles", perf_cycles, 0);
`endif
    @(posedge clk); #1;

    // 3: three samples, mid-batch input changes ignored
    d0 = n_done; l0 = n_ld; r0 = n_rds;
    start_batch(2, 3, t0);
    num_coeff = 4'd7;
    batch_len = 4'd9;
    push_batch(t0, 2, 3);
    wait_idle();
    check_eq("t3_done_count", n_done - d0, 1);
    check_eq("t3_ld_result_count", n_ld - l0, 3);
    check_eq("t3_rd_en_signal_count", n_rds - r0, 3);

    // 4: zero coefficients, batch_len 0 treated as 1
    d0 = n_done; l0 = n_ld;
    start_batch(0, 0, t0);
    push_batch(t0, 0, 0);
    wait_idle();
    check_eq("t4_done_count", n_done - d0, 1);
    check_eq("t4_ld_result_count", n_ld - l0, 1);

    // 5: result back-pressure for 5 cycles
    d0 = n_done;
    result_ready = 1'b0;
    start_batch(1, 1, t0);
    exp_rc.push_back(t0 + 3);
    exp_em.push_back('{cyc: t0 + 20, dn: 1'b1});
    k = 0;
    while (!result_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("t5_emit_start", cyc, t0 + 15);
    for (int i = 0; i < 5; i++) begin
      check_eq("t5_valid_held", result_valid, 1);
      check_eq("t5_ld_held", ld_result, 1);
      check_eq("t5_no_rd_sig", rd_en_signal, 0);
      check_eq("t5_no_done", done, 0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    result_ready = 1'b1;
    wait_idle();
    check_eq("t5_done_count", n_done - d0, 1);

    // 6a: abort during WAIT
    d0 = n_done;
    start_batch(2, 1, t0);
    exp_rc.push_back(t0 + 3);
    goto_cyc(t0 + 6);
    abort = 1'b1;
    @(negedge clk);
    check_eq("t6a_redo_data", redo_data, 1);
    check_eq("t6a_rd_en_coeff", rd_en_coeff, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check_eq("t6a_load", busy, 0);
    goto_cyc(t0 + 40);
    check_eq("t6a_no_done", n_done - d0, 0);

    // 6b: abort with result_ready in EMIT
    d0 = n_done;
    start_batch(0, 2, t0);
    goto_cyc(t0 + 3);
    abort = 1'b1;
    @(negedge clk);
    check_eq("t6b_done", done, 0);
    check_eq("t6b_result_valid", result_valid, 0);
    check_eq("t6b_ld_result", ld_result, 0);
    check_eq("t6b_rd_en_signal", rd_en_signal, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check_eq("t6b_load", busy, 0);
    check_eq("t6b_no_done", n_done - d0, 0);
    @(posedge clk); #1;

    // 6c: reset asserted in FETCH
    start_batch(2, 1, t0);
    goto_cyc(t0 + 3);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t6c_rd_en_coeff", rd_en_coeff, 0);
    check_eq("t6c_rst_reg_n", rst_reg_n, 0);
    check_eq("t6c_redo_data", redo_data, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t6c_load", busy, 0);
    check_eq("t6c_perf_reset", perf_cycles, 0);
    @(posedge clk); #1;

    // Recovery batch after reset
    d0 = n_done;
    start_batch(1, 2, t0);
    push_batch(t0, 1, 2);
    wait_idle();
    check_eq("t7_done_count", n_done - d0, 1);

    check_eq("sb_rd_en_coeff_left", exp_rc.size(), 0);
    check_eq("sb_emit_left", exp_em.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
